// File: rtl/store_narrower.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | store_narrower: narrows byte/half/word stores onto a word-only memory     |
// | (no byte enables), using read-modify-write for sub-word stores.           |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module store_narrower #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int MEM_AW = 30
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              st_valid,
  output logic              st_ready,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [DATA_W-1:0] st_data,
  input  logic [1:0]        st_size,
  output logic              st_done,
  output logic              st_err,
  output logic [MEM_AW-1:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_wr_en,
  output logic [DATA_W-1:0] mem_wdata
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_MERGE = 3'd2,
    S_WRITE = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [1:0]        r_lane;
  logic              r_half;
  logic [15:0]       r_data;
  logic [MEM_AW-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] w_merged;
  logic              w_bad;
  logic              w_accept;

  assign w_accept  = (r_state == S_IDLE) && st_valid;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_wdata;

  always_comb begin
    w_bad = 1'b0;
    case (st_size)
      2'b01:   w_bad = st_addr[0];
      2'b10:   w_bad = (st_addr[1:0] != 2'b00);
      2'b11:   w_bad = 1'b1;
      default: w_bad = 1'b0;
    endcase
  end

  always_comb begin
    w_next    = r_state;
    st_ready  = 1'b0;
    st_done   = 1'b0;
    st_err    = 1'b0;
    mem_rd_en = 1'b0;
    mem_wr_en = 1'b0;
    case (r_state)
      S_IDLE: begin
        st_ready = 1'b1;
        if (st_valid) begin
          if (w_bad)                  w_next = S_ERR;
          else if (st_size == 2'b10)  w_next = S_WRITE;
          else                        w_next = S_READ;
        end
      end
      S_READ: begin
        mem_rd_en = 1'b1;
        w_next    = S_MERGE;
      end
      S_MERGE: w_next = S_WRITE;
      S_WRITE: begin
        mem_wr_en = 1'b1;
        st_done   = 1'b1;
        w_next    = S_IDLE;
      end
      S_ERR: begin
        st_err = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Only the addressed lane(s) take store data; the rest come from memory.
  always_comb begin
    w_merged = mem_rdata;
    if (r_half) begin
      if (r_lane[1]) w_merged[31:16] = r_data;
      else           w_merged[15:0]  = r_data;
    end else begin
      case (r_lane)
        2'd0:    w_merged[7:0]   = r_data[7:0];
        2'd1:    w_merged[15:8]  = r_data[7:0];
        2'd2:    w_merged[23:16] = r_data[7:0];
        default: w_merged[31:24] = r_data[7:0];
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_lane     <= 2'b00;
      r_half     <= 1'b0;
      r_data     <= '0;
      r_mem_addr <= '0;
      r_wdata    <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_lane     <= st_addr[1:0];
        r_half     <= st_size[0];
        r_data     <= st_data[15:0];
        r_mem_addr <= st_addr[ADDR_W-1:2];
        if (st_size == 2'b10 && !w_bad)
          r_wdata <= st_data;
      end
      if (r_state == S_MERGE)
        r_wdata <= w_merged;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_store_narrower.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_store_narrower: randomized self-checking bench against a word-array    |
// | reference model of the memory.  Revision: 1.0                              |
// +----------------------------------------------------------------------------+
module tb_store_narrower;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        st_valid;
  logic        st_ready;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [1:0]  st_size;
  logic        st_done;
  logic        st_err;
  logic [29:0] mem_addr;
  logic        mem_rd_en;
  logic [31:0] mem_rdata;
  logic        mem_wr_en;
  logic [31:0] mem_wdata;

  logic [31:0] mem     [16];
  logic [31:0] init_val[16];
  logic [31:0] ref_mem [16];
  logic        load;

  int n_chk = 0;
  int n_err = 0;

  store_narrower #(.DATA_W(32), .ADDR_W(32), .MEM_AW(30)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .st_valid  (st_valid),
    .st_ready  (st_ready),
    .st_addr   (st_addr),
    .st_data   (st_data),
    .st_size   (st_size),
    .st_done   (st_done),
    .st_err    (st_err),
    .mem_addr  (mem_addr),
    .mem_rd_en (mem_rd_en),
    .mem_rdata (mem_rdata),
    .mem_wr_en (mem_wr_en),
    .mem_wdata (mem_wdata)
  );

  always #5 clk = ~clk;

  // Word-wide memory: read data one cycle after the strobe.
  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < 16; i++) mem[i] <= init_val[i];
    end else begin
      if (mem_rd_en) mem_rdata <= mem[mem_addr[3:0]];
      if (mem_wr_en) mem[mem_addr[3:0]] <= mem_wdata;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issue one request (caller is at a negedge with the unit idle) and check
  // every cycle until ready returns. With hold, valid stays high and the
  // next request is presented while the unit is busy.
  task automatic run_req(input logic [31:0] addr, input logic [1:0] size, input logic [31:0] data,
                         input bit hold, input logic [31:0] naddr, input logic [1:0] nsize,
                         input logic [31:0] ndata);
    bit          bad;
    bit          sub;
    int          lat;
    int          wr_k;
    int          sh;
    logic [31:0] old;
    logic [31:0] mask;
    logic [31:0] expw;
    logic [3:0]  idx;
    bad  = (size == 2'd3) || (size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 2'd0);
    sub  = !bad && (size != 2'd2);
    idx  = addr[5:2];
    old  = ref_mem[idx];
    expw = data;
    if (size == 2'd0) begin
      sh   = 8 * int'(addr[1:0]);
      mask = 32'hFF << sh;
      expw = (old & ~mask) | ((data & 32'hFF) << sh);
    end else if (size == 2'd1) begin
      sh   = 16 * int'(addr[1]);
      mask = 32'hFFFF << sh;
      expw = (old & ~mask) | ((data & 32'hFFFF) << sh);
    end
    lat  = sub ? 4 : 2;
    wr_k = bad ? 0 : (sub ? 3 : 1);
    st_valid = 1'b1;
    st_addr  = addr;
    st_size  = size;
    st_data  = data;
    check("ready_accept", 32'(st_ready), 32'd1);
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      if (hold) begin
        st_addr = naddr;
        st_size = nsize;
        st_data = ndata;
      end else begin
        st_valid = 1'b0;
      end
      check("ready",  32'(st_ready),  32'(k == lat));
      check("rd_en",  32'(mem_rd_en), 32'(sub && k == 1));
      check("wr_en",  32'(mem_wr_en), 32'(k == wr_k));
      check("done",   32'(st_done),   32'(k == wr_k));
      check("err",    32'(st_err),    32'(bad && k == 1));
      if (sub && k == 1) check("rd_addr", 32'(mem_addr), addr >> 2);
      if (k == wr_k) begin
        check("wr_addr", 32'(mem_addr), addr >> 2);
        check("wdata", mem_wdata, expw);
      end
    end
    if (!bad) ref_mem[idx] = expw;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] a;
    logic [1:0]  s;
    logic [31:0] d;
    for (int i = 0; i < 16; i++) init_val[i] = $urandom;
    init_val[4] = 32'hAABBCCDD;
    init_val[1] = 32'h11223344;
    for (int i = 0; i < 16; i++) ref_mem[i] = init_val[i];
    load     = 1'b1;
    rst_n    = 1'b0;
    st_valid = 1'b0;
    st_addr  = '0;
    st_size  = '0;
    st_data  = '0;
    repeat (3) @(negedge clk);
    load = 1'b0;
    check("rst_ready", 32'(st_ready),  32'd1);
    check("rst_rd",    32'(mem_rd_en), 32'd0);
    check("rst_wr",    32'(mem_wr_en), 32'd0);
    check("rst_done",  32'(st_done),   32'd0);
    check("rst_err",   32'(st_err),    32'd0);
    check("rst_addr",  32'(mem_addr),  32'd0);
    check("rst_wdata", mem_wdata,      32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_req(32'h12, 2'd0, 32'hFFFFFF5A, 1'b0, '0, '0, '0);
    check("tp_byte_mem", mem[4], 32'hAA5ACCDD);
    run_req(32'h06, 2'd1, 32'h0000BEEF, 1'b0, '0, '0, '0);
    check("tp_half_mem", mem[1], 32'hBEEF3344);
    run_req(32'h20, 2'd2, 32'hDEADBEEF, 1'b0, '0, '0, '0);
    check("tp_word_mem", mem[8], 32'hDEADBEEF);
    run_req(32'h03, 2'd1, $urandom, 1'b0, '0, '0, '0);
    run_req(32'h02, 2'd2, $urandom, 1'b0, '0, '0, '0);
    run_req(32'h15, 2'd3, $urandom, 1'b0, '0, '0, '0);

    // Back-to-back byte stores into the same word with valid held high.
    d = $urandom;
    run_req(32'h08, 2'd0, $urandom, 1'b1, 32'h0B, 2'd0, d);
    run_req(32'h0B, 2'd0, d, 1'b0, '0, '0, '0);
    check("b2b_mem", mem[2], ref_mem[2]);

    // Reset during MERGE abandons the store.
    st_valid = 1'b1;
    st_addr  = 32'h05;
    st_size  = 2'd0;
    st_data  = $urandom;
    @(negedge clk);
    st_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_ready", 32'(st_ready),  32'd1);
    check("mid_rst_rd",    32'(mem_rd_en), 32'd0);
    check("mid_rst_wr",    32'(mem_wr_en), 32'd0);
    check("mid_rst_done",  32'(st_done),   32'd0);
    check("mid_rst_addr",  32'(mem_addr),  32'd0);
    check("mid_rst_wdata", mem_wdata,      32'd0);
    @(negedge clk);
    check("mid_rst_wr2",   32'(mem_wr_en), 32'd0);
    check("mid_rst_done2", 32'(st_done),   32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("mid_rst_mem", mem[1], ref_mem[1]);
    run_req(32'h05, 2'd0, $urandom, 1'b0, '0, '0, '0);

    for (int n = 0; n < 60; n++) begin
      a = 32'($urandom_range(0, 63));
      s = 2'($urandom_range(0, 3));
      d = $urandom;
      run_req(a, s, d, 1'b0, '0, '0, '0);
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end

    @(negedge clk);
    for (int i = 0; i < 16; i++) check("final_mem", mem[i], ref_mem[i]);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/store_narrower.md
Name: store_narrower

Overview:
- Store-side counterpart to the load path's sign/zero extenders: narrows a 32-bit register value to byte, halfword or word and writes it into a word-addressed, word-wide data memory.
- The memory has no byte enables, so sub-word stores run as a read-modify-write sequence.
- Sits between the datapath's store request and the data memory.
- Little-endian byte lanes throughout.

Parameters:
- DATA_W, 32, register and memory word width; fixed at 32 (4 byte lanes).
- ADDR_W, 32, byte-address width of st_addr.
- MEM_AW, 30, word-address width of mem_addr; must equal ADDR_W-2.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- st_valid  input  1  store request valid.
- st_ready  output  1  unit can accept a request (high only in IDLE).
- st_addr  input  ADDR_W  byte address of the store.
- st_data  input  DATA_W  register value; only the low 8/16/32 bits are used.
- st_size  input  2  00 = byte, 01 = half, 10 = word, 11 = illegal.
- st_done  output  1  one-cycle pulse when the memory write is issued.
- st_err  output  1  one-cycle pulse for a misaligned or illegal-size request.
- mem_addr  output  MEM_AW  word address, st_addr[ADDR_W-1:2].
- mem_rd_en  output  1  memory read strobe.
- mem_rdata  input  DATA_W  read data, valid exactly one cycle after mem_rd_en.
- mem_wr_en  output  1  memory write strobe.
- mem_wdata  output  DATA_W  write data.

Behaviour:
- One clock (clk). Reset is asynchronous, active-low (rst_n).
- Reset values:
  - state = IDLE.
  - st_ready = 1; st_done, st_err, mem_rd_en, mem_wr_en = 0.
  - mem_addr = 0, mem_wdata = 0.
  - Latched request registers cleared.
- States: IDLE, READ, MERGE, WRITE, ERR.
- IDLE:
  - st_ready = 1.
  - On st_valid, latch st_addr, st_data, st_size.
  - Next state:
    - ERR if size = 11, or size = 01 with addr[0] = 1, or size = 10 with addr[1:0] != 00.
    - WRITE if size = 10.
    - READ otherwise.
- READ: mem_rd_en = 1 for one cycle, mem_addr = latched word address. Next state MERGE.
- MERGE:
  - Capture mem_rdata and replace the addressed lane(s):
    - Byte: lane addr[1:0] (bits 8*k+7:8*k) takes st_data[7:0].
    - Half: lanes addr[1] selects bits 15:0 or 31:16, taking st_data[15:0].
  - All other bits keep mem_rdata.
  - Result is registered into mem_wdata. Next state WRITE.
- WRITE:
  - mem_wr_en = 1 and st_done = 1 for one cycle; mem_addr holds.
  - For word stores, mem_wdata = st_data unmodified.
  - Next state IDLE.
- ERR: st_err = 1 for one cycle. No memory strobe. Next state IDLE.
- Latency, counting the acceptance cycle as T:
  - Sub-word store: rd_en at T+1, wr_en/done at T+3, st_ready again at T+4.
  - Word store: wr_en/done at T+1, ready at T+2.
  - Error: err at T+1, ready at T+2.
- Exclusivity:
  - st_done and st_err are never high together.
  - mem_rd_en and mem_wr_en are never high together.
- Input sampling: inputs are sampled only in IDLE. st_valid is ignored while st_ready = 0; no queuing.
- mem_addr holds its last value in IDLE.
- Reset mid-operation: return to IDLE immediately with all strobes low. An in-flight write is abandoned if reset asserts before WRITE; no done pulse is produced.
- Sub-word upper bits: upper st_data bits never leak into unaddressed lanes. Sign is irrelevant on store (pure truncation).

Test Plan:
- Byte store, lane 2: mem word at 0x10 = 0xAABBCCDD; st_addr = 0x12, size = 00, st_data = 0xFFFFFF5A. Required: rd_en at T+1 with mem_addr = 0x4, wr_en at T+3 with mem_wdata = 0xAA5ACCDD, st_done at T+3.
- Half store, upper: mem word = 0x11223344; addr = 0x06, size = 01, data = 0x0000BEEF. Required: mem_wdata = 0xBEEF3344, mem_addr = 0x1.
- Word store: addr = 0x20, size = 10, data = 0xDEADBEEF. Required: no rd_en, wr_en/done at T+1, mem_wdata = 0xDEADBEEF, mem_addr = 0x8.
- Errors: addr = 0x03 with size = 01; addr = 0x02 with size = 10; size = 11 at any addr. Required for each: st_err pulse at T+1, no mem strobes, st_ready back at T+2.
- Back-to-back: two byte stores with st_valid held high. Required: second accepted only at T+4, and both writes correct.
- Reset: assert rst_n low during MERGE. Required: outputs immediately at reset values, no wr_en, no done; the next request after release completes normally.
